// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the registered ALU control sequencer.
package alu_ctrl_pkg;

  // Primary opcodes (inst[5:0])
  localparam logic [5:0] OP_RTYPE = 6'h3A;
  localparam logic [5:0] OP_ORHI  = 6'h34;
  localparam logic [5:0] OP_ORI   = 6'h14;
  localparam logic [5:0] OP_LDW   = 6'h17;
  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_STW   = 6'h15;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] OP_BLT   = 6'h16;

  // R-type extended opcodes (inst[16:11])
  localparam logic [5:0] OPX_ADD  = 6'h31;
  localparam logic [5:0] OPX_MUL  = 6'h27;
  localparam logic [5:0] OPX_SUB  = 6'h39;
  localparam logic [5:0] OPX_AND  = 6'h0E;
  localparam logic [5:0] OPX_OR   = 6'h16;

  // ALU control codes
  localparam int         ALU_W     = 3;
  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_MUL   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_CMPLT = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_MULWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode: inst -> {ALU code, multi-cycle flag, illegal}.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int EN_LOGIC = 1
) (
  input  logic [31:0]      inst,
  output logic [ALU_W-1:0] code,
  output logic             is_mul,
  output logic             illegal
);

  logic [5:0] w_op;
  logic [5:0] w_opx;
  logic       w_rtype;
  logic       w_unused;

  assign w_op     = inst[5:0];
  assign w_opx    = inst[16:11];
  assign w_rtype  = (w_op == OP_RTYPE) && (inst[10:6] == 5'd0);
  // Immediate/register fields play no part in ALU selection.
  assign w_unused = ^inst[31:17];

  // Opcode/opx lookup; everything unrecognised falls through to NOP + illegal.
  always_comb begin
    code    = ALU_NOP;
    is_mul  = 1'b0;
    illegal = 1'b1;
    if (w_rtype) begin
      case (w_opx)
        OPX_ADD: begin code = ALU_ADD; illegal = 1'b0; end
        OPX_MUL: begin code = ALU_MUL; illegal = 1'b0; is_mul = 1'b1; end
        OPX_SUB: if (EN_LOGIC != 0) begin code = ALU_SUB; illegal = 1'b0; end
        OPX_AND: if (EN_LOGIC != 0) begin code = ALU_AND; illegal = 1'b0; end
        OPX_OR:  if (EN_LOGIC != 0) begin code = ALU_OR;  illegal = 1'b0; end
        default: ;
      endcase
    end else begin
      case (w_op)
        OP_ORHI, OP_ORI, OP_LDW, OP_ADDI, OP_STW, OP_BR: begin
          code = ALU_ADD; illegal = 1'b0;
        end
        OP_BLT: begin code = ALU_CMPLT; illegal = 1'b0; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, valid/ready ALU control sequencer with multiply latency tracking.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W   = 3,
  parameter int MUL_LAT  = 3,
  parameter int EN_LOGIC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic              mul_start,
  output logic              busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t             r_state, w_nxt_state;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [ALU_W-1:0]   r_code, w_nxt_code;
  logic               r_illegal, w_nxt_illegal;
  logic               r_ctrl_valid, w_nxt_ctrl_valid;
  logic               r_mul_start, w_nxt_mul_start;

  logic [ALU_W-1:0]   w_dec_code;
  logic               w_dec_mul;
  logic               w_dec_illegal;
  logic               w_accept;

  alu_ctrl_decode #(.EN_LOGIC(EN_LOGIC)) u_decode (
    .inst    (inst),
    .code    (w_dec_code),
    .is_mul  (w_dec_mul),
    .illegal (w_dec_illegal)
  );

  // A slot is free when idle, or when the held result leaves this cycle.
  assign inst_ready = !reset && !flush &&
                      ((r_state == S_IDLE) || ((r_state == S_ISSUE) && ctrl_ready));
  assign w_accept   = inst_valid && inst_ready;

  assign alu_ctrl   = CTRL_W'(r_code);
  assign illegal    = r_illegal;
  assign ctrl_valid = r_ctrl_valid;
  assign mul_start  = r_mul_start;
  assign busy       = (r_state != S_IDLE);

  // Next-state and next-output selection; hold everything unless a transition fires.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_code       = r_code;
    w_nxt_illegal    = r_illegal;
    w_nxt_ctrl_valid = r_ctrl_valid;
    w_nxt_mul_start  = 1'b0;

    case (r_state)
      S_IDLE, S_ISSUE: begin
        if (w_accept) begin
          if (w_dec_mul) begin
            w_nxt_state      = S_MULWAIT;
            w_nxt_cnt        = CNT_W'(MUL_LAT - 1);
            w_nxt_code       = ALU_MUL;
            w_nxt_illegal    = 1'b0;
            w_nxt_ctrl_valid = 1'b0;
            w_nxt_mul_start  = 1'b1;
          end else begin
            w_nxt_state      = S_ISSUE;
            w_nxt_code       = w_dec_code;
            w_nxt_illegal    = w_dec_illegal;
            w_nxt_ctrl_valid = 1'b1;
          end
        end else if ((r_state == S_ISSUE) && ctrl_ready) begin
          w_nxt_state      = S_IDLE;
          w_nxt_ctrl_valid = 1'b0;
        end
      end
      S_MULWAIT: begin
        if (r_cnt == '0) begin
          w_nxt_state      = S_ISSUE;
          w_nxt_ctrl_valid = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state      = S_IDLE;
        w_nxt_ctrl_valid = 1'b0;
      end
    endcase
  end

  // State and output registers; reset and flush both clear everything and drop the input.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_code       <= ALU_NOP;
      r_illegal    <= 1'b0;
      r_ctrl_valid <= 1'b0;
      r_mul_start  <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_code       <= w_nxt_code;
      r_illegal    <= w_nxt_illegal;
      r_ctrl_valid <= w_nxt_ctrl_valid;
      r_mul_start  <= w_nxt_mul_start;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: two instances share stimulus.
//   u_a: MUL_LAT=3, EN_LOGIC=1   u_b: MUL_LAT=1, EN_LOGIC=0
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset, flush, inst_valid, ctrl_ready;
  logic [31:0] inst;

  logic       a_ir, a_ill, a_cv, a_ms, a_busy;
  logic [2:0] a_alu;
  logic       b_ir, b_ill, b_cv, b_ms, b_busy;
  logic [2:0] b_alu;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.CTRL_W(3), .MUL_LAT(3), .EN_LOGIC(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(a_ir), .alu_ctrl(a_alu), .illegal(a_ill), .ctrl_valid(a_cv),
    .ctrl_ready(ctrl_ready), .mul_start(a_ms), .busy(a_busy));

  alu_ctrl_seq #(.CTRL_W(3), .MUL_LAT(1), .EN_LOGIC(0)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(b_ir), .alu_ctrl(b_alu), .illegal(b_ill), .ctrl_valid(b_cv),
    .ctrl_ready(ctrl_ready), .mul_start(b_ms), .busy(b_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; inst_valid = 1'b0; ctrl_ready = 1'b1; inst = 32'h0;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; inst_valid = 1'b1; ctrl_ready = 1'b1; inst = 32'h4;
    step(); step();
    n_tests++;
    if ({a_alu, a_ill, a_cv, a_ms, a_busy, a_ir} !== 8'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b want 00000000", {a_alu, a_ill, a_cv, a_ms, a_busy, a_ir});
    end
    reset = 1'b0; inst_valid = 1'b0;
    #1;
    n_tests++;
    if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", a_ir); end
  endtask

  task automatic test_addi();
    do_reset();
    inst = 32'h0000_0004; inst_valid = 1'b1; ctrl_ready = 1'b1;
    step();
    inst_valid = 1'b0;
    n_tests++;
    if ({a_cv, a_alu, a_ill, a_busy} !== 6'b1_001_0_1) begin
      n_fail++; $display("FAIL addi_issue: got cv/alu/ill/busy=%b want 100101", {a_cv, a_alu, a_ill, a_busy});
    end
    step();
    n_tests++;
    if ({a_cv, a_busy} !== 2'b00) begin
      n_fail++; $display("FAIL addi_idle: got cv/busy=%b want 00", {a_cv, a_busy});
    end
  endtask

  task automatic test_mul();
    do_reset();
    inst = 32'h0001_383A; inst_valid = 1'b1; ctrl_ready = 1'b1;
    step();
    inst_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (a_ms !== (k == 1)) begin n_fail++; $display("FAIL mul_start[%0d]: got %b want %b", k, a_ms, (k == 1)); end
      n_tests++;
      if (a_cv !== (k == 4)) begin n_fail++; $display("FAIL mul_valid[%0d]: got %b want %b", k, a_cv, (k == 4)); end
      n_tests++;
      if (a_ir !== (k == 4)) begin n_fail++; $display("FAIL mul_ready[%0d]: got %b want %b", k, a_ir, (k == 4)); end
      n_tests++;
      if (b_cv !== (k == 2)) begin n_fail++; $display("FAIL mul_lat1_valid[%0d]: got %b want %b", k, b_cv, (k == 2)); end
      if (k == 2) begin
        n_tests++;
        if (b_alu !== 3'b011) begin n_fail++; $display("FAIL mul_lat1_code: got %b want 011", b_alu); end
      end
      if (k == 4) begin
        n_tests++;
        if ({a_alu, a_ill} !== 4'b011_0) begin n_fail++; $display("FAIL mul_code: got %b want 0110", {a_alu, a_ill}); end
      end
      step();
    end
    n_tests++;
    if ({a_cv, a_busy} !== 2'b00) begin n_fail++; $display("FAIL mul_done: got %b want 00", {a_cv, a_busy}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    inst = 32'h0000_0016; inst_valid = 1'b1; ctrl_ready = 1'b1;
    step();
    inst = 32'h0000_0014;
    n_tests++;
    if ({a_cv, a_alu, a_ir} !== 5'b1_101_1) begin
      n_fail++; $display("FAIL b2b_first: got cv/alu/ir=%b want 11011", {a_cv, a_alu, a_ir});
    end
    step();
    inst_valid = 1'b0;
    n_tests++;
    if ({a_cv, a_alu} !== 4'b1_001) begin
      n_fail++; $display("FAIL b2b_second: got cv/alu=%b want 1001", {a_cv, a_alu});
    end
    step();
    n_tests++;
    if (a_cv !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", a_cv); end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst = 32'h0000_0004; inst_valid = 1'b1; ctrl_ready = 1'b0;
    step();
    inst = 32'h0000_0016;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({a_cv, a_alu, a_ir, a_ill} !== 6'b1_001_0_0) begin
        n_fail++; $display("FAIL stall[%0d]: got cv/alu/ir/ill=%b want 100100", k, {a_cv, a_alu, a_ir, a_ill});
      end
      step();
    end
    inst_valid = 1'b0; ctrl_ready = 1'b1;
    #1;
    n_tests++;
    if ({a_cv, a_alu, a_ir} !== 5'b1_001_1) begin
      n_fail++; $display("FAIL stall_release: got %b want 10011", {a_cv, a_alu, a_ir});
    end
    step();
    n_tests++;
    if ({a_cv, a_busy} !== 2'b00) begin n_fail++; $display("FAIL stall_idle: got %b want 00", {a_cv, a_busy}); end
  endtask

  task automatic test_decode();
    // inst, expected {alu,ill} for EN_LOGIC=1 and EN_LOGIC=0
    logic [31:0] vi [10] = '{32'h0000_003F, 32'h0000_703A, 32'h0000_0034, 32'h0000_0017,
                             32'h0000_0015, 32'h0000_0006, 32'h0001_883A, 32'h0001_C83A,
                             32'h0000_B03A, 32'h0001_887A};
    logic [3:0]  ea [10] = '{4'b000_1, 4'b100_0, 4'b001_0, 4'b001_0, 4'b001_0,
                             4'b001_0, 4'b001_0, 4'b010_0, 4'b110_0, 4'b000_1};
    logic [3:0]  eb [10] = '{4'b000_1, 4'b000_1, 4'b001_0, 4'b001_0, 4'b001_0,
                             4'b001_0, 4'b001_0, 4'b000_1, 4'b000_1, 4'b000_1};
    do_reset();
    ctrl_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      inst = vi[k]; inst_valid = 1'b1;
      step();
      n_tests++;
      if ({a_cv, a_alu, a_ill} !== {1'b1, ea[k]}) begin
        n_fail++; $display("FAIL dec_a[%h]: got cv/alu/ill=%b want %b", vi[k], {a_cv, a_alu, a_ill}, {1'b1, ea[k]});
      end
      n_tests++;
      if ({b_cv, b_alu, b_ill} !== {1'b1, eb[k]}) begin
        n_fail++; $display("FAIL dec_b[%h]: got cv/alu/ill=%b want %b", vi[k], {b_cv, b_alu, b_ill}, {1'b1, eb[k]});
      end
    end
    inst_valid = 1'b0;
    step();
  endtask

  task automatic test_flush_mulwait();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      inst = 32'h0001_383A; inst_valid = 1'b1; ctrl_ready = 1'b1;
      step();                       // accepted, MULWAIT cycle 1
      inst_valid = 1'b0;
      step();                       // MULWAIT cycle 2
      n_tests++;
      if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort%0d_pre_busy: got %b want 1", v, a_busy); end
      if (v == 0) flush = 1'b1; else reset = 1'b1;
      inst = 32'h0000_0004; inst_valid = 1'b1;
      #1;
      n_tests++;
      if (a_ir !== 1'b0) begin n_fail++; $display("FAIL abort%0d_ready: got %b want 0", v, a_ir); end
      step();
      flush = 1'b0; reset = 1'b0; inst_valid = 1'b0;
      n_tests++;
      if ({a_alu, a_ill, a_cv, a_ms, a_busy} !== 7'b0) begin
        n_fail++; $display("FAIL abort%0d_clear: got %b want 0000000", v, {a_alu, a_ill, a_cv, a_ms, a_busy});
      end
      step();                       // dropped addi must not appear
      n_tests++;
      if (a_cv !== 1'b0) begin n_fail++; $display("FAIL abort%0d_drop: got %b want 0", v, a_cv); end
      inst = 32'h0000_0004; inst_valid = 1'b1;
      step();
      inst_valid = 1'b0;
      n_tests++;
      if ({a_cv, a_alu, a_ill} !== 5'b1_001_0) begin
        n_fail++; $display("FAIL abort%0d_after: got %b want 10010", v, {a_cv, a_alu, a_ill});
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inst_valid = 1'b0; ctrl_ready = 1'b1; inst = 32'h0;
    test_reset();
    test_addi();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_decode();
    test_flush_mulwait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
